// File: rtl/ofm_stream_out.sv
// ---------------------------------------------------------------------------
// ofm_stream_out
//
// Drains the output-feature-map buffer (fifo_ofm) onto a 32-bit AXI4-Stream
// master feeding the AXI DMA S2MM channel. A start pulse in IDLE begins one
// frame. The block reads the buffer one 4-byte word per read cycle at
// addresses 0, 4, 8, ... DATA_DEPTH-4 and emits one stream beat per read.
// TLAST marks the final beat, and done pulses for one cycle once that beat
// has been accepted.
//
// Optional feature (compile-time macro):
//   OFM_STREAM_BYTE_SWAP_EN  when defined, the byte order of each word is
//                            reversed so that the byte at buf_addr lands in
//                            tdata[7:0]. When undefined, tdata = buf_q, and
//                            the byte at buf_addr sits in tdata[31:24].
//
// Parameters:
//   DATA_WIDTH   byte width of one buffer entry (stream width = 4*DATA_WIDTH)
//   DATA_DEPTH   buffer entries drained per frame (multiple of 4)
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   rstn           asynchronous active-low reset
//   start          one-cycle request to drain a frame (honoured in IDLE only)
//   busy           high while this block owns the buffer read port (RUN)
//   done           one-cycle pulse after the last beat is accepted
//   buf_ce         buffer enable, high only on read cycles
//   buf_we         buffer write enable, tied low
//   buf_addr       byte address of the 4-byte read (multiple of 4)
//   buf_q          buffer read data, combinational in the read cycle
//   m_axis_tdata   stream data
//   m_axis_tvalid  stream valid
//   m_axis_tready  stream ready
//   m_axis_tlast   high on the final beat of the frame only
//   fsm_state      current FSM state (0 = IDLE, 1 = RUN) for observation
// ---------------------------------------------------------------------------
module ofm_stream_out #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 2304
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    buf_ce,
    output logic                    buf_we,
    output logic [11:0]             buf_addr,
    input  logic [DATA_WIDTH*4-1:0] buf_q,
    output logic [DATA_WIDTH*4-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [0:0]              fsm_state
);

    localparam int NUM_WORDS = DATA_DEPTH / 4;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam int SW        = DATA_WIDTH * 4;

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] WORDS_CNT = CNT_W'(NUM_WORDS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] rd_cnt;     // words read from the buffer this frame
    logic [CNT_W-1:0] tx_cnt;     // beats accepted by the stream sink
    logic [11:0]      addr_hold;  // last issued address, held between reads

    logic             rd_en;
    logic             hs;
    logic             last_hs;
    logic [31:0]      addr_wide;
    logic [11:0]      rd_addr;
    logic [SW-1:0]    word_in;

    // Stream handshake: a beat transfers on any rising edge where tvalid and
    // tready are both high. Once tvalid is raised, tdata/tlast are frozen and
    // tvalid stays high until that transfer. tvalid is a register, so it never
    // depends combinationally on tready; only the read enable looks at tready
    // so the output register can be refilled in the same cycle it drains.
    always_comb begin
        hs      = m_axis_tvalid && m_axis_tready;
        rd_en   = (state == ST_RUN) && (rd_cnt < WORDS_CNT) &&
                  (!m_axis_tvalid || m_axis_tready);
        last_hs = (state == ST_RUN) && hs && (tx_cnt == LAST_IDX);
    end

    // Byte address = word index * 4, truncated to the 12-bit buffer port.
    always_comb begin
        addr_wide = 32'({rd_cnt, 2'b00});
        rd_addr   = addr_wide[11:0];
    end

    always_comb begin
        buf_ce    = rd_en;
        buf_we    = 1'b0;
        buf_addr  = rd_en ? rd_addr : addr_hold;
        busy      = (state == ST_RUN);
        fsm_state = state;
    end

    // Word formatting. The buffer presents the byte at buf_addr in the top
    // byte lane; the DMA may want it in the bottom lane instead.
    always_comb begin
        word_in = buf_q;
`ifdef OFM_STREAM_BYTE_SWAP_EN
        for (int i = 0; i < 4; i++) begin
            word_in[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[(3-i)*DATA_WIDTH +: DATA_WIDTH];
        end
`endif
    end

    // Control FSM and frame counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            rd_cnt <= '0;
            tx_cnt <= '0;
            done   <= 1'b0;
        end else begin
            done <= last_hs;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        rd_cnt <= '0;
                        tx_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored here: no restart mid-frame.
                    if (rd_en) begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                    if (hs) begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                    if (last_hs) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stream output register. A read always refills it; a handshake without
    // a refill empties it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            addr_hold     <= '0;
        end else if (rd_en) begin
            m_axis_tdata  <= word_in;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (rd_cnt == LAST_IDX);
            addr_hold     <= rd_addr;
        end else if (hs) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ofm_stream_out.sv
// ---------------------------------------------------------------------------
// tb_ofm_stream_out
//
// Bench for ofm_stream_out. A combinational buffer model answers reads with
// byte k = (k + pat_base) mod 256. A negedge monitor scores every accepted
// beat against a queue of expected words built from that byte rule, tracks
// issued addresses, stall stability and frame timing. The main sequence runs
// full-rate, random-backpressure, ignored-start, mid-frame reset,
// back-to-back and pre-stalled frames.
// ---------------------------------------------------------------------------
module tb_ofm_stream_out;

  localparam int DW    = 8;
  localparam int DEPTH = 2304;
  localparam int NW    = DEPTH / 4;
  localparam int W     = DW * 4;

`ifdef OFM_STREAM_BYTE_SWAP_EN
  localparam logic [W-1:0] EXP_FIRST = 32'h0302_0100;
  localparam logic [W-1:0] EXP_LAST  = 32'hFFFE_FDFC;
`else
  localparam logic [W-1:0] EXP_FIRST = 32'h0001_0203;
  localparam logic [W-1:0] EXP_LAST  = 32'hFCFD_FEFF;
`endif

  // clock / reset / DUT signals
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         m_axis_tready = 1'b0;
  logic         busy, done, buf_ce, buf_we, m_axis_tvalid, m_axis_tlast;
  logic [11:0]  buf_addr;
  logic [W-1:0] buf_q_m;
  logic [W-1:0] m_axis_tdata;
  logic [0:0]   fsm_state;

  always #5 clk = ~clk;

  ofm_stream_out #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .buf_ce        (buf_ce),
    .buf_we        (buf_we),
    .buf_addr      (buf_addr),
    .buf_q         (buf_q_m),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .fsm_state     (fsm_state)
  );

  // buffer model: garbage outside read cycles so mistimed captures show up
  logic [7:0] pat_base = 8'd0;
  always_comb begin
    buf_q_m = buf_ce ? {buf_addr[7:0] + pat_base,
                        buf_addr[7:0] + 8'd1 + pat_base,
                        buf_addr[7:0] + 8'd2 + pat_base,
                        buf_addr[7:0] + 8'd3 + pat_base}
                     : 32'hDEAD_BEEF;
  end

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference: beat n of a frame, from the byte rule alone
  function automatic logic [W-1:0] exp_beat(input int n, input int base);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = 8'((4 * n + i + base) % 256);
`ifdef OFM_STREAM_BYTE_SWAP_EN
    return {b[3], b[2], b[1], b[0]};
`else
    return {b[0], b[1], b[2], b[3]};
`endif
  endfunction

  // monitor bookkeeping
  int cyc = 0;
  int start_cyc = 0;
  int hs_last = 0;
  int beat_idx = 0;
  int reads = 0;
  int exp_addr = 0;
  int done_total = 0;
  bit saw_stall = 1'b0;
  bit first_valid_seen = 1'b1;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;
  logic [W-1:0] first_data = '0;
  logic [W-1:0] last_data = '0;
  logic [W-1:0] mon_exp;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      check_eq("buf_we_low", 64'(buf_we), 64'(0));
      if (done) begin
        done_total++;
        check_eq("done_busy_excl", 64'(busy), 64'(0));
        check_eq("done_timing", 64'(cyc), 64'(hs_last + 1));
        check_eq("frame_beats", 64'(beat_idx), 64'(NW));
        check_eq("frame_reads", 64'(reads), 64'(NW));
        if (!saw_stall) check_eq("frame_len", 64'(hs_last - start_cyc), 64'(NW + 1));
      end
      if (prev_stall) begin
        check_eq("stall_valid", 64'(m_axis_tvalid), 64'(1));
        check_eq("stall_data", 64'(m_axis_tdata), 64'(prev_data));
        check_eq("stall_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        check_eq("ce_in_stall", 64'(buf_ce), 64'(0));
        saw_stall = 1'b1;
      end
      if (buf_ce) begin
        check_eq("ce_busy", 64'(busy), 64'(1));
        check_eq("rd_addr", 64'(buf_addr), 64'(exp_addr));
        exp_addr += 4;
        reads++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("beat_extra", 64'(1), 64'(0));
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq("beat_data", 64'(m_axis_tdata), 64'(mon_exp));
          check_eq("beat_last", 64'(m_axis_tlast), 64'(beat_idx == NW - 1));
          if (beat_idx == 0) first_data = m_axis_tdata;
          if (beat_idx == NW - 1) last_data = m_axis_tdata;
        end
        beat_idx++;
        hs_last = cyc;
      end
      if (start && !busy) begin
        start_cyc = cyc;
        beat_idx = 0;
        reads = 0;
        exp_addr = 0;
        saw_stall = 1'b0;
        first_valid_seen = 1'b0;
        first_data = '0;
        last_data = '0;
        exp_q.delete();
        for (int n = 0; n < NW; n++) exp_q.push_back(exp_beat(n, int'(pat_base)));
      end
      if (m_axis_tvalid && !first_valid_seen) begin
        first_valid_seen = 1'b1;
        check_eq("first_valid_cyc", 64'(cyc), 64'(start_cyc + 2));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // driver tasks
  bit rnd_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  // returns just after the edge that raises done (inside the done cycle)
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check_eq("done_wait", 64'(done), 64'(1));
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog expired t=%0t", $time);
    summary();
    $fatal(1, "watchdog");
  end

  int d0;
  int n;
  bit p10, p300;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_ce", 64'(buf_ce), 64'(0));
    check_eq("rst_we", 64'(buf_we), 64'(0));
    check_eq("rst_addr", 64'(buf_addr), 64'(0));
    check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check_eq("rst_tdata", 64'(m_axis_tdata), 64'(0));
    check_eq("rst_state", 64'(fsm_state), 64'(0));
    rstn = 1'b1;
    tick();
    tick();

    // full-rate frame
    m_axis_tready = 1'b1;
    d0 = done_total;
    start = 1'b1;
    tick();
    wait_done(NW + 50);
    tick();
    check_eq("f1_done_cnt", 64'(done_total - d0), 64'(1));
    check_eq("f1_first", 64'(first_data), 64'(EXP_FIRST));
    check_eq("f1_last", 64'(last_data), 64'(EXP_LAST));

    // random backpressure, random pattern base
    pat_base = 8'($urandom);
    rnd_ready = 1'b1;
    d0 = done_total;
    start = 1'b1;
    tick();
    wait_done(NW * 12);
    rnd_ready = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    check_eq("f2_done_cnt", 64'(done_total - d0), 64'(1));

    // start pulses mid-frame are ignored
    pat_base = 8'd0;
    d0 = done_total;
    start = 1'b1;
    tick();
    n = 0; p10 = 1'b0; p300 = 1'b0;
    while (!done && n < NW + 50) begin
      if (!p10 && beat_idx >= 10) begin start = 1'b1; p10 = 1'b1; end
      else if (!p300 && beat_idx >= 300) begin start = 1'b1; p300 = 1'b1; end
      tick();
      n++;
    end
    check_eq("f3_done_wait", 64'(done), 64'(1));
    repeat (10) tick();
    check_eq("f3_idle_after", 64'(busy), 64'(0));
    check_eq("f3_done_cnt", 64'(done_total - d0), 64'(1));

    // asynchronous reset at beat 100
    start = 1'b1;
    tick();
    n = 0;
    while (!(beat_idx >= 100 && m_axis_tvalid) && n < 300) begin
      tick();
      n++;
    end
    check_eq("f4_tvalid_before_rst", 64'(m_axis_tvalid), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    check_eq("f4_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("f4_rst_busy", 64'(busy), 64'(0));
    check_eq("f4_rst_ce", 64'(buf_ce), 64'(0));
    check_eq("f4_rst_tlast", 64'(m_axis_tlast), 64'(0));
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    d0 = done_total;
    start = 1'b1;
    tick();
    wait_done(NW + 50);
    tick();
    check_eq("f4_done_cnt", 64'(done_total - d0), 64'(1));
    check_eq("f4_first", 64'(first_data), 64'(EXP_FIRST));

    // back-to-back frames, second start in the done cycle
    d0 = done_total;
    start = 1'b1;
    tick();
    wait_done(NW + 50);
    start = 1'b1;
    tick();
    check_eq("b2b_busy", 64'(busy), 64'(1));
    check_eq("b2b_ce", 64'(buf_ce), 64'(1));
    check_eq("b2b_addr0", 64'(buf_addr), 64'(0));
    wait_done(NW + 50);
    tick();
    check_eq("b2b_done_cnt", 64'(done_total - d0), 64'(2));

    // tready low before start: one read then hold
    m_axis_tready = 1'b0;
    d0 = done_total;
    start = 1'b1;
    tick();
    repeat (6) tick();
    check_eq("pre_reads", 64'(reads), 64'(1));
    check_eq("pre_tvalid", 64'(m_axis_tvalid), 64'(1));
    check_eq("pre_ce", 64'(buf_ce), 64'(0));
    check_eq("pre_tdata", 64'(m_axis_tdata), 64'(EXP_FIRST));
    m_axis_tready = 1'b1;
    #1;
    check_eq("pre_rise_ce", 64'(buf_ce), 64'(1));
    check_eq("pre_rise_addr", 64'(buf_addr), 64'(4));
    tick();
    m_axis_tready = 1'b0;
    #1;
    check_eq("pre_beats", 64'(beat_idx), 64'(1));
    check_eq("pre_next_valid", 64'(m_axis_tvalid), 64'(1));
    check_eq("pre_next_data", 64'(m_axis_tdata), 64'(exp_beat(1, 0)));
    m_axis_tready = 1'b1;
    wait_done(NW + 50);
    tick();
    check_eq("pre_done_cnt", 64'(done_total - d0), 64'(1));

    repeat (3) tick();
    summary();
    $finish;
  end

endmodule

// File: doc/ofm_stream_out.md
# ofm_stream_out

Drains the output-feature-map buffer (`fifo_ofm`) onto a 32-bit AXI4-Stream master toward the AXI DMA S2MM channel. On a `start` pulse it reads the buffer four bytes at a time, addresses 0, 4, 8, … up to DATA_DEPTH-4, and emits one stream beat per read. It asserts TLAST on the final beat and pulses `done`. It sits directly downstream of `fifo_ofm` and drives that buffer's read port. The top level muxes the buffer port between the compute engine (write) and this block (read) using `busy`.

## Interface
- DATA_WIDTH, 8: byte width of one buffer entry; stream width is DATA_WIDTH*4.
- DATA_DEPTH, 2304: buffer entries drained per frame; must be a multiple of 4. NUM_WORDS = DATA_DEPTH/4 (576).

- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to drain one frame; honoured only in IDLE.
- busy  out  1  high while the block owns the buffer read port (RUN state).
- done  out  1  one-cycle pulse after the last beat is accepted.
- buf_ce  out  1  buffer enable; high only on read cycles.
- buf_we  out  1  buffer write enable; constant 0 (read).
- buf_addr  out  12  byte address of the 4-byte read; always a multiple of 4.
- buf_q  in  DATA_WIDTH*4  buffer read data; combinational in the same cycle as `buf_ce`=1, `buf_we`=0. byte at buf_addr is in [31:24].
- m_axis_tdata  out  DATA_WIDTH*4  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on beat NUM_WORDS-1 only.

## Operation
- States: IDLE, RUN.
  - IDLE→RUN on `start`=1; clears the read counter rd_cnt and the beat counter tx_cnt.
  - RUN→IDLE on the edge where beat NUM_WORDS-1 handshakes. `done`=1 for the following cycle.
- Read enable, rd_en = RUN && rd_cnt<NUM_WORDS && (!m_axis_tvalid || m_axis_tready).
- `buf_ce` = rd_en. `buf_addr` = rd_cnt*4, truncated to 12 bits. No read is issued otherwise (`buf_ce`=0, `buf_addr` holds its value).
- On rd_en:
  - `m_axis_tdata` ← buf_q (byte order per Configuration).
  - `m_axis_tvalid` ← 1.
  - `m_axis_tlast` ← (rd_cnt==NUM_WORDS-1).
  - rd_cnt increments.
- On handshake without rd_en: `m_axis_tvalid` ← 0 and `m_axis_tlast` ← 0.
- Handshake (tvalid && tready) increments tx_cnt.
- AXIS rules:
  - Once tvalid=1, tdata and tlast hold until the handshake.
  - tvalid never drops without a handshake.
  - tvalid does not depend combinationally on tready.
- `start` while in RUN is ignored; no restart or counter change.
- The compute engine must not write the buffer while `busy`=1. This block does not check for it.

## Timing
- Reset values:
  - state IDLE, busy 0, done 0.
  - buf_ce 0, buf_we 0, buf_addr 0.
  - m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0.
  - rd_cnt 0, tx_cnt 0.
- The start pulse is sampled at edge 0, giving RUN from cycle 1. The first read (buf_ce=1, addr 0) is in cycle 1, and the first tvalid is in cycle 2.
- With tready held high: one beat per cycle, the frame takes NUM_WORDS+1 cycles from start to the last handshake, and `done` follows one cycle later.
- Backpressure: while tready=0 with tvalid=1, no read is issued. Reading resumes in the same cycle that tready returns high (zero bubble).
- An asynchronous reset mid-frame immediately forces IDLE and the reset values. The partial frame is dropped with no TLAST. A new `start` is needed.
- `done` and `busy` are never both high. `start` in the `done` cycle is accepted.

## Configuration
- OFM_STREAM_BYTE_SWAP_EN defined: tdata = {buf_q[7:0], buf_q[15:8], buf_q[23:16], buf_q[31:24]}. The byte at buf_addr lands in tdata[7:0] (little-endian for the DMA).
- Not defined: tdata = buf_q unchanged. The byte at buf_addr is in tdata[31:24].

## Test plan
- Reset, then `start` with tready=1 and the buffer model holding byte k = k mod 256:
  - 576 beats on consecutive cycles; beat 0 = 0x00010203 (0x03020100 with swap).
  - tlast only on beat 575 = 0xFCFDFEFF.
  - done one cycle after it.
- Random tready (50%):
  - Identical data sequence.
  - tdata/tlast stable while stalled.
  - No address issued twice or skipped.
  - buf_ce=0 in every stall cycle.
- `start` pulsed at beats 10 and 300 mid-frame: ignored; exactly 576 beats and one done.
- rstn deasserted at beat 100 with tvalid=1:
  - tvalid, busy and buf_ce drop asynchronously.
  - The next `start` restarts at addr 0 with beat 0 = 0x00010203.
- Back-to-back frames, with `start` issued in the done cycle: the second frame begins with no lost cycle and produces 576 beats again.
- tready=0 from before start:
  - exactly one read is issued (addr 0) and tvalid holds.
  - when tready rises for one cycle, the beat is accepted and addr 4 is read in the same cycle.
